lpf_sched: RTL and testbench

LPF_SCHED -- requirements
Module: lpf_sched

---
 rtl/lpf_sched.sv | 205 ++++++++++++++++++++
 tb/tb_lpf_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_sched.sv
// lpf_sched -- four-channel first-order low-pass filter bank sharing one
// multiply datapath, scheduled by a programmable sample-tick counter.
//
// Each channel computes y = b0*(x + x_old) - a1*y_old in Q1.15 with
// round-half-up and saturation. Channels are processed 0..3 in order,
// two cycles each (MUL, ACC), followed by a DONE cycle that pulses y_valid.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   en           sample-tick enable (counter held at 0 while low)
//   x_in         four signed Q1.15 inputs, channel n at [16n+15:16n]
//   cfg_we       config write strobe
//   cfg_addr     0-3 b0[ch], 4-7 a1[ch], 8 period, 9-15 ignored
//   cfg_wdata    config write data
//   y_out        four signed Q1.15 outputs, same packing as x_in
//   y_valid      one-cycle pulse after all four outputs are updated
//   busy         high while the datapath is sequencing
//   overrun_cnt  saturating count of ticks dropped while busy
//
// Optional feature: define LPF_SCHED_OVERRUN_EN to build the overrun
// counter; without it overrun_cnt is tied to 0.
module lpf_sched #(
  parameter int PERIOD_DEFAULT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] x_in,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [63:0] y_out,
  output logic        y_valid,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ch_reg, ch_next;

  // ---------------- tick scheduler ----------------
  logic [15:0] period_reg;
  logic [15:0] cnt_reg;
  logic [15:0] period_eff;
  logic        period_wr;
  logic        tick;

  assign period_wr  = cfg_we && (cfg_addr == 4'd8);
  // Periods of 0 and 1 both mean "tick every enabled cycle".
  assign period_eff = (period_reg < 16'd2) ? 16'd1 : period_reg;
  assign tick       = en && (cnt_reg == (period_eff - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      period_reg <= 16'(PERIOD_DEFAULT);
      cnt_reg    <= '0;
    end else begin
      if (period_wr)
        period_reg <= cfg_wdata;
      // A period write restarts the count even if it lands on a tick.
      if (period_wr || !en || tick)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // ---------------- per-channel state ----------------
  // Flattened buses let the shared datapath select a channel by ch_reg.
  logic [63:0] b0_bus, a1_bus, xs_bus, x_old_bus, y_old_bus;
  logic signed [15:0] y_sat;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic [15:0] b0_reg, a1_reg, xs_reg, x_old_reg, y_old_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        b0_reg    <= '0;
        a1_reg    <= '0;
        xs_reg    <= '0;
        x_old_reg <= '0;
        y_old_reg <= '0;
      end else begin
        if (cfg_we && (cfg_addr == 4'(gi)))
          b0_reg <= cfg_wdata;
        if (cfg_we && (cfg_addr == 4'(gi + 4)))
          a1_reg <= cfg_wdata;
        if ((state_reg == IDLE) && tick)
          xs_reg <= x_in[16*gi +: 16];
        if ((state_reg == ACC) && (ch_reg == 2'(gi))) begin
          y_old_reg <= y_sat;
          x_old_reg <= xs_reg;
        end
      end
    end

    assign b0_bus[16*gi +: 16]    = b0_reg;
    assign a1_bus[16*gi +: 16]    = a1_reg;
    assign xs_bus[16*gi +: 16]    = xs_reg;
    assign x_old_bus[16*gi +: 16] = x_old_reg;
    assign y_old_bus[16*gi +: 16] = y_old_reg;
    // The output register and the feedback state always hold the same
    // value, so one register serves both.
    assign y_out[16*gi +: 16]     = y_old_reg;
  end

  // ---------------- shared datapath ----------------
  logic signed [15:0] b0_sel, a1_sel, xs_sel, xo_sel, yo_sel;
  logic signed [16:0] sum_sel;
  logic signed [32:0] p_b_reg;
  logic signed [31:0] p_a_reg;
  logic signed [33:0] acc_sum;
  logic signed [33:0] acc_shr;

  assign b0_sel  = b0_bus[16*ch_reg +: 16];
  assign a1_sel  = a1_bus[16*ch_reg +: 16];
  assign xs_sel  = xs_bus[16*ch_reg +: 16];
  assign xo_sel  = x_old_bus[16*ch_reg +: 16];
  assign yo_sel  = y_old_bus[16*ch_reg +: 16];
  assign sum_sel = {xs_sel[15], xs_sel} + {xo_sel[15], xo_sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      p_b_reg <= '0;
      p_a_reg <= '0;
    end else if (state_reg == MUL) begin
      p_b_reg <= b0_sel * sum_sel;
      p_a_reg <= a1_sel * yo_sel;
    end
  end

  // Round half up, then back to Q1.15 with saturation.
  assign acc_sum = p_b_reg - p_a_reg + 34'sd16384;
  assign acc_shr = acc_sum >>> 15;

  always_comb begin
    y_sat = acc_shr[15:0];
    if (acc_shr > 34'sd32767)
      y_sat = 16'sh7FFF;
    else if (acc_shr < -34'sd32768)
      y_sat = 16'sh8000;
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    case (state_reg)
      IDLE: if (tick) begin
        state_next = MUL;
        ch_next    = 2'd0;
      end
      MUL:  state_next = ACC;
      ACC:  if (ch_reg == 2'd3) begin
        state_next = DONE;
      end else begin
        state_next = MUL;
        ch_next    = ch_reg + 2'd1;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign y_valid = (state_reg == DONE);
  assign busy    = (state_reg != IDLE);

  // ---------------- overrun counter ----------------
`ifdef LPF_SCHED_OVERRUN_EN
  logic [7:0] overrun_reg;
  logic       drop;

  assign drop = tick && (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst)
      overrun_reg <= '0;
    else if (drop && (overrun_reg != 8'hFF))
      overrun_reg <= overrun_reg + 8'd1;
  end

  assign overrun_cnt = overrun_reg;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_lpf_sched.sv
// Testbench for lpf_sched: scoreboard of expected y_out vectors filled from
// a behavioural filter model when samples are scheduled, checked on y_valid.
module tb_lpf_sched;

  logic        clk = 1'b0;
  logic        rst, en, cfg_we;
  logic [63:0] x_in;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [63:0] y_out;
  logic        y_valid, busy;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  lpf_sched #(.PERIOD_DEFAULT(20)) dut (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic signed [15:0] m_b0[4], m_a1[4], m_xo[4], m_yo[4];
  bit ovr_mode = 1'b0;
  bit lat_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_y(input logic signed [15:0] b0, a1, x, xo, yo);
    longint acc;
    acc = longint'(b0) * (longint'(x) + longint'(xo)) - longint'(a1) * longint'(yo);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_b0[c] = '0; m_a1[c] = '0; m_xo[c] = '0; m_yo[c] = '0;
    end
    exp_q.delete();
  endtask

  task automatic push_samples(input int n);
    logic [63:0] v;
    logic signed [15:0] xv, yv;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < 4; c++) begin
        xv = x_in[16*c +: 16];
        yv = model_y(m_b0[c], m_a1[c], xv, m_xo[c], m_yo[c]);
        m_xo[c] = xv;
        m_yo[c] = yv;
        v[16*c +: 16] = yv;
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    if (a < 4'd4) m_b0[a[1:0]] = d;
    else if (a < 4'd8) m_a1[a[1:0]] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Enable ticks until n outputs have been produced, then stop.
  task automatic run_samples(input int n);
    int got;
    got = 0;
    push_samples(n);
    en = 1'b1;
    for (int i = 0; i < n * 40 + 60; i++) begin
      @(negedge clk);
      if (y_valid) got++;
      if (got == n) break;
    end
    en = 1'b0;
    check("valid_count", got, n);
  endtask

  // Monitor: scoreboard pop on y_valid, plus latency/busy timing in lat_mode.
  int   mon_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  bit   have_fall = 1'b0, prev_lat = 1'b0;
  logic prev_busy = 1'b0;
  logic [63:0] mon_exp;

  always @(negedge clk) begin
    mon_cyc++;
    if (lat_mode && !prev_lat) have_fall = 1'b0;
    prev_lat = lat_mode;
    if (lat_mode) begin
      if (busy && !prev_busy) begin
        if (have_fall) check("busy_low", mon_cyc - fall_cyc, 3);
        rise_cyc = mon_cyc;
      end
      if (!busy && prev_busy) begin
        check("busy_high", mon_cyc - rise_cyc, 9);
        fall_cyc  = mon_cyc;
        have_fall = 1'b1;
      end
      if (y_valid) check("latency", mon_cyc - rise_cyc, 8);
    end
    prev_busy = busy;
    if (y_valid && !ovr_mode) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        $display("txn y_out=%h exp=%h", y_out, mon_exp);
        check("y_out", y_out, mon_exp);
      end else begin
        check("spurious_valid", {63'd0, y_valid}, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; x_in = '0;

    // Reset state and first-tick timing with the default period.
    do_reset();
    check("rst_y_out", y_out, 64'd0);
    check("rst_y_valid", {63'd0, y_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_overrun", {56'd0, overrun_cnt}, 64'd0);
    push_samples(1);
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (y_valid) break;
    end
    en = 1'b0;
    check("first_valid_cycle", n, 28);

    // Step response.
    for (int c = 0; c < 4; c++) cfg_write(4'(c), 16'h4000);
    x_in = {4{16'h2000}};
    run_samples(2);
    check("step_final", y_out, {4{16'h2000}});

    // Latency and busy profile with period 12, mixed coefficients.
    cfg_write(4'd8, 16'd12);
    cfg_write(4'd0, 16'h4000); cfg_write(4'd1, 16'h2000);
    cfg_write(4'd2, 16'h6000); cfg_write(4'd3, 16'h1000);
    cfg_write(4'd4, 16'hC000); cfg_write(4'd5, 16'h1000);
    cfg_write(4'd6, 16'h8000); cfg_write(4'd7, 16'h7000);
    x_in = {16'hF000, 16'h1234, 16'h7000, 16'h8001};
    @(negedge clk);
    lat_mode = 1'b1;
    run_samples(3);
    repeat (3) @(negedge clk);
    lat_mode = 1'b0;

    // Saturation from a clean state, default period.
    do_reset();
    cfg_write(4'd0, 16'h3000); cfg_write(4'd4, 16'hE000);
    cfg_write(4'd1, 16'h7FFF); cfg_write(4'd5, 16'h7FFF);
    cfg_write(4'd2, 16'h7FFF); cfg_write(4'd6, 16'h8000);
    cfg_write(4'd3, 16'h0100);
    x_in = {16'h0123, 16'h7FFF, 16'h8000, 16'h4000};
    run_samples(2);
    check("sat_ch2", {48'd0, y_out[47:32]}, 64'h7FFF);

    // Reset during the ch1 ACC cycle aborts the sequence.
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) begin n = 1; break; end
    end
    check("mid_busy_seen", n, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_y_out", y_out, 64'd0);
    check("mid_y_valid", {63'd0, y_valid}, 64'd0);
    rst = 1'b0;
    model_clear();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (y_valid) n++;
    end
    check("mid_no_valid", n, 0);

    // Overrun: period 5 drops every other tick.
    do_reset();
    ovr_mode = 1'b1;
    cfg_write(4'd8, 16'd5);
    en = 1'b1;
    repeat (100) @(negedge clk);
`ifdef LPF_SCHED_OVERRUN_EN
    check("overrun_100", {56'd0, overrun_cnt}, 64'd10);
`else
    check("overrun_100", {56'd0, overrun_cnt}, 64'd0);
`endif
    repeat (2900) @(negedge clk);
`ifdef LPF_SCHED_OVERRUN_EN
    check("overrun_sat", {56'd0, overrun_cnt}, 64'd255);
`else
    check("overrun_sat", {56'd0, overrun_cnt}, 64'd0);
`endif
    en = 1'b0;
    repeat (20) @(negedge clk);
    ovr_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
